// File: rtl/updown_timer_pkg.sv
// Shared types and encodings for the up/down timer counter.
package updown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/updown_timer_counter_tick_prescaler.sv
// Step-strobe generator: one tick every (div+1) enabled cycles.
module tick_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] div,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] phase;

  // The tick fires in the same cycle the phase reaches the divisor.
  assign tick = en && (phase == div);

  // Phase counter: cleared by reset/clear, frozen while disabled.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the values present before the clock edge.
    if (rst || clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= tick ? '0 : phase + ONE;
    end
  end

endmodule

// File: rtl/updown_timer_counter.sv
// Up/down timer counter with modulo, wrap/saturate, load, prescaler and flags.
module updown_timer_counter
  import updown_timer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  dir,
  input  logic                  sat_mode,
  input  logic [WIDTH-1:0]      modulo,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  running,
  output logic                  tc,
  output logic                  overflow
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state;
  logic             step;
  logic [WIDTH-1:0] step_count;
  logic             step_boundary;
  logic             step_wrap;

  assign running = (state == RUN);

  // Load and clear both restart the prescale phase from zero.
  tick_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (clear || load),
    .en  (state == RUN),
    .div (prescale),
    .tick(step)
  );

  // Next count if a step is taken this cycle, plus boundary/wrap qualifiers.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    step_count    = count;
    step_boundary = 1'b0;
    step_wrap     = 1'b0;
    if (dir == DIR_UP) begin
      if (count >= modulo) begin
        step_boundary = 1'b1;
        if (sat_mode == MODE_SAT) begin
          step_count = modulo;
        end else begin
          step_count = '0;
          step_wrap  = 1'b1;
        end
      end else begin
        step_count = count + ONE;
      end
    end else begin
      if (count == '0) begin
        step_boundary = 1'b1;
        if (sat_mode == MODE_SAT) begin
          step_count = '0;
        end else begin
          step_count = modulo;
          step_wrap  = 1'b1;
        end
      end else begin
        step_count = count - ONE;
      end
    end
  end

  // FSM, count register and flags; priority rst > clear > load > stop > start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      tc       <= 1'b0;
      overflow <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      count    <= '0;
      tc       <= 1'b0;
      overflow <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        count <= load_val;
      end else begin
        if (step) begin
          count <= step_count;
          tc    <= step_boundary;
          if (step_wrap) begin
            overflow <= 1'b1;
          end
        end
        if (stop) begin
          if (state == RUN) begin
            state <= HOLD;
          end
        end else if (start && state != RUN) begin
          state <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_updown_timer_counter.sv
// Self-checking bench for updown_timer_counter: directed scenarios followed
// by randomized control traffic, all compared against a behavioural model.
module tb_updown_timer_counter;

  localparam int WIDTH      = 8;
  localparam int PRESCALE_W = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic                  stop = 1'b0;
  logic                  clear = 1'b0;
  logic                  load = 1'b0;
  logic [WIDTH-1:0]      load_val = '0;
  logic                  dir = 1'b0;
  logic                  sat_mode = 1'b0;
  logic [WIDTH-1:0]      modulo = '1;
  logic [PRESCALE_W-1:0] prescale = '0;
  logic [WIDTH-1:0]      count;
  logic                  running;
  logic                  tc;
  logic                  overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: mode is one of three named activities.
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;

  int m_mode  = M_IDLE;
  int m_count = 0;
  int m_pre   = 0;
  bit m_tc    = 1'b0;
  bit m_ovf   = 1'b0;

  updown_timer_counter #(
    .WIDTH     (WIDTH),
    .PRESCALE_W(PRESCALE_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .clear   (clear),
    .load    (load),
    .load_val(load_val),
    .dir     (dir),
    .sat_mode(sat_mode),
    .modulo  (modulo),
    .prescale(prescale),
    .count   (count),
    .running (running),
    .tc      (tc),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One counting step from the rules: climb to modulo or descend to zero.
  task automatic model_step();
    int lim;
    lim = int'(modulo);
    if (dir == 1'b0) begin
      if (m_count < lim) begin
        m_count = m_count + 1;
      end else begin
        m_tc = 1'b1;
        if (sat_mode) m_count = lim;
        else begin
          m_count = 0;
          m_ovf   = 1'b1;
        end
      end
    end else begin
      if (m_count > 0) begin
        m_count = m_count - 1;
      end else begin
        m_tc = 1'b1;
        if (sat_mode) m_count = 0;
        else begin
          m_count = lim;
          m_ovf   = 1'b1;
        end
      end
    end
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_next();
    bit step_now;
    if (rst || clear) begin
      m_mode  = M_IDLE;
      m_count = 0;
      m_pre   = 0;
      m_tc    = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      m_tc     = 1'b0;
      step_now = (m_mode == M_RUN) && (m_pre == int'(prescale));
      if (load) begin
        m_pre   = 0;
        m_count = int'(load_val);
      end else begin
        if (m_mode == M_RUN) m_pre = step_now ? 0 : m_pre + 1;
        if (step_now) model_step();
        if (stop) begin
          if (m_mode == M_RUN) m_mode = M_HOLD;
        end else if (start) begin
          m_mode = M_RUN;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, {24'b0, count}, m_count);
    check({tag, ".running"}, {31'b0, running}, (m_mode == M_RUN) ? 1 : 0);
    check({tag, ".tc"}, {31'b0, tc}, {31'b0, m_tc});
    check({tag, ".overflow"}, {31'b0, overflow}, {31'b0, m_ovf});
  endtask

  // Inputs are driven #1 after an edge; outputs are sampled #1 after the next.
  task automatic cycle(input string tag);
    model_next();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset and free run from zero.
    rst = 1'b1;
    cycle("reset0");
    cycle("reset1");
    rst = 1'b0; start = 1'b1; prescale = 4'd0; modulo = 8'd255; dir = 1'b0;
    for (int i = 0; i < 6; i++) cycle("run");
    check("run.count_after_6", {24'b0, count}, 32'd5);

    // Up wrap at modulo 9.
    start = 1'b0; clear = 1'b1;
    cycle("wrap.clear");
    clear = 1'b0; load = 1'b1; load_val = 8'd8; modulo = 8'd9;
    cycle("wrap.load");
    load = 1'b0; start = 1'b1;
    cycle("wrap.enter");
    cycle("wrap.nine");
    cycle("wrap.zero");
    check("wrap.count_zero", {24'b0, count}, 32'd0);
    check("wrap.tc_pulse", {31'b0, tc}, 32'd1);
    check("wrap.ovf_set", {31'b0, overflow}, 32'd1);
    cycle("wrap.one");
    check("wrap.ovf_sticky", {31'b0, overflow}, 32'd1);
    for (int i = 0; i < 10; i++) cycle("wrap.more");

    // Down saturate from 2.
    start = 1'b0; clear = 1'b1;
    cycle("dsat.clear");
    clear = 1'b0; load = 1'b1; load_val = 8'd2; dir = 1'b1; sat_mode = 1'b1;
    cycle("dsat.load");
    load = 1'b0; start = 1'b1;
    cycle("dsat.enter");
    for (int i = 0; i < 4; i++) cycle("dsat.step");
    check("dsat.count_held", {24'b0, count}, 32'd0);
    check("dsat.tc_repulse", {31'b0, tc}, 32'd1);
    check("dsat.ovf_clear", {31'b0, overflow}, 32'd0);

    // Prescale by 4, then hold and resume.
    start = 1'b0; clear = 1'b1; prescale = 4'd3; dir = 1'b0; sat_mode = 1'b0; modulo = 8'd255;
    cycle("pre.clear");
    clear = 1'b0; start = 1'b1;
    for (int i = 0; i < 10; i++) cycle("pre.run");
    start = 1'b0; stop = 1'b1;
    for (int i = 0; i < 5; i++) cycle("pre.hold");
    stop = 1'b0; start = 1'b1;
    for (int i = 0; i < 8; i++) cycle("pre.resume");

    // Priority collisions.
    start = 1'b0; clear = 1'b1; load = 1'b1; load_val = 8'h33; prescale = 4'd0;
    cycle("coll.clear_load");
    check("coll.clear_wins_count", {24'b0, count}, 32'd0);
    check("coll.clear_wins_idle", {31'b0, running}, 32'd0);
    clear = 1'b0; load = 1'b0; start = 1'b1;
    cycle("coll.enter");
    cycle("coll.step");
    load = 1'b1; load_val = 8'h44;
    cycle("coll.load_step");
    check("coll.load_wins", {24'b0, count}, 32'h44);
    load = 1'b0; start = 1'b0; stop = 1'b1;
    cycle("coll.hold");
    stop = 1'b0; clear = 1'b1;
    cycle("coll.idle");
    clear = 1'b0; start = 1'b1; stop = 1'b1;
    cycle("coll.start_stop");
    check("coll.stays_idle", {31'b0, running}, 32'd0);
    start = 1'b0; stop = 1'b0;

    // Reset in the middle of a run with overflow set.
    clear = 1'b1; modulo = 8'd0; prescale = 4'd0;
    cycle("mrst.clear");
    clear = 1'b0; start = 1'b1;
    cycle("mrst.enter");
    cycle("mrst.mod0");
    load = 1'b1; load_val = 8'h5A; prescale = 4'd15; modulo = 8'd255;
    cycle("mrst.load");
    load = 1'b0;
    cycle("mrst.wait");
    check("mrst.pre_count", {24'b0, count}, 32'h5A);
    check("mrst.pre_ovf", {31'b0, overflow}, 32'd1);
    rst = 1'b1;
    cycle("mrst.reset");
    check("mrst.count", {24'b0, count}, 32'd0);
    check("mrst.running", {31'b0, running}, 32'd0);
    check("mrst.tc", {31'b0, tc}, 32'd0);
    check("mrst.overflow", {31'b0, overflow}, 32'd0);
    rst = 1'b0;

    // Randomized control traffic; prescale only moves when the phase restarts.
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 99) < 2);
      clear = ($urandom_range(0, 99) < 4);
      load  = ($urandom_range(0, 99) < 6);
      stop  = ($urandom_range(0, 99) < 12);
      start = ($urandom_range(0, 99) < 30);
      load_val = 8'($urandom);
      if ($urandom_range(0, 9) == 0) dir = 1'($urandom);
      if ($urandom_range(0, 9) == 0) sat_mode = 1'($urandom);
      if ($urandom_range(0, 9) == 0)
        modulo = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
      if (rst || clear || load) prescale = 4'($urandom_range(0, 3));
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_timer_counter.md
Name: updown_timer_counter

Overview:
Parametrised successor to the 8-bit start/stop counter used on tt_um pin-level designs. Adds width, up/down direction, programmable modulo, wrap or saturate mode, parallel load, a clock prescaler, a terminal-count pulse and a sticky overflow flag. Sits behind the top-level pin wrapper, with controls driven from ui_in/uio_in and count driven to uo_out.

Parameters:
WIDTH, 8, counter width in bits (2..32)
PRESCALE_W, 4, width of the prescale divisor input (1..16)

Ports:
clk  in  1  single clock, all state on posedge
rst  in  1  synchronous reset, active-high
start  in  1  level; requests RUN
stop  in  1  level; requests HOLD
clear  in  1  synchronous clear of count, prescaler and overflow
load  in  1  parallel load strobe
load_val  in  WIDTH  value taken on load
dir  in  1  0 = count up, 1 = count down
sat_mode  in  1  0 = wrap at boundary, 1 = saturate at boundary
modulo  in  WIDTH  terminal value for up-count and reload value for down-wrap
prescale  in  PRESCALE_W  one count step per (prescale+1) RUN cycles
count  out  WIDTH  current count
running  out  1  high in RUN state
tc  out  1  one-cycle pulse on a boundary step
overflow  out  1  sticky; set on any wrap event

Behaviour:
- Reset (rst=1 at posedge): count=0, state=IDLE, prescaler=0, tc=0, overflow=0, running=0. rst overrides all other inputs.
- States are IDLE, RUN and HOLD. running=1 only in RUN.
- Priority each cycle: rst > clear > load > stop > start.
- Transitions:
  - IDLE or HOLD: start=1 and stop=0 -> RUN.
  - RUN: stop=1 -> HOLD. stop wins if start and stop are both high.
  - clear -> IDLE.
  - load does not change state.
- clear: count=0, prescaler=0, overflow=0, tc=0 on the next cycle.
- load (without clear): count=load_val and prescaler=0 on the next cycle. No step occurs that cycle. tc=0. load_val is not range-checked against modulo.
- Prescaler:
  - Increments only in RUN.
  - A step fires on the cycle the prescaler equals prescale. The prescaler then returns to 0.
  - prescale=0 gives a step every RUN cycle.
  - The prescaler holds its value in HOLD.
- Step, up (dir=0):
  - count < modulo: count+1.
  - count >= modulo (boundary): wrap gives count=0, tc=1, overflow=1. Saturate gives count=modulo, tc=1, overflow unchanged.
- Step, down (dir=1):
  - count > 0: count-1.
  - count == 0 (boundary): wrap gives count=modulo, tc=1, overflow=1. Saturate holds 0, tc=1.
- tc is registered and asserted for exactly the cycle after the boundary step, aligned with the updated count. In saturate mode, tc re-pulses on every further step while held at the boundary.
- modulo=0: count stays 0 and every step is a boundary.
- Changing dir, modulo or sat_mode mid-run takes effect on the next step. No other side effect.
- Latency: a control input seen at posedge N is reflected on count/running at N+1. The first step after entering RUN occurs prescale+1 cycles after the entry edge.
- All arithmetic is WIDTH-bit unsigned. No carry out beyond tc/overflow.

Decomposition:
- Package updown_timer_pkg holds:
  - the state typedef (IDLE=2'd0, RUN=2'd1, HOLD=2'd2);
  - localparams for the dir encoding (DIR_UP=0, DIR_DOWN=1) and the mode encoding (MODE_WRAP=0, MODE_SAT=1).
- One sub-module, tick_prescaler, with ports clk, rst, clr, en, div[PRESCALE_W] and tick. It produces the step strobe. The top block holds the FSM, the count datapath and the flags.

Test Plan:
- Reset and run: rst=1 for 2 cycles, then start=1, prescale=0, modulo=255, dir=0 -> count goes 0,1,2,... each cycle; running=1 one cycle after start.
- Up wrap: WIDTH=8, modulo=9, prescale=0, wrap mode -> count 8,9,0 with tc=1 exactly when count=0. overflow=1 and stays 1 until clear.
- Down saturate: load_val=2, dir=1, sat_mode=1, prescale=0 -> count 2,1,0,0,0. tc pulses on each step at 0. overflow stays 0.
- Prescaler and hold: prescale=3 -> count increments every 4 cycles. stop=1 for 5 cycles freezes count and prescaler. Releasing stop and asserting start resumes with the remaining prescale phase.
- Priority collisions:
  - clear and load in the same cycle -> count=0, state=IDLE.
  - load and step in the same cycle -> count=load_val.
  - start and stop together from IDLE -> stays IDLE.
- Reset mid-operation: RUN with count=0x5A and overflow=1; assert rst for 1 cycle -> next cycle count=0, running=0, tc=0, overflow=0.
